// File: rtl/gb_fetch_pkg.sv
// rtl/gb_fetch_pkg.sv - shared types and defaults for the instruction fetch stage
// Purpose: fetch FSM state encoding, default prefetch depth and the opcode type
//          shared between the fetch stage and the processor interface.
// Ports:   none (package).
package gb_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam int FETCH_DEPTH_DEFAULT = 4;

  typedef logic [7:0] opcode_t;

endpackage

// File: rtl/gb_fetch_fifo.sv
// rtl/gb_fetch_fifo.sv - prefetch FIFO with a registered head output
// Purpose: buffers opcode bytes returned by the ROM; the head entry is held in
//          an output register so instruction/valid come straight from flops.
// Ports:   clk_i, rst_ni (async, active-low)
//          push_i, wdata_i    write one byte
//          pop_i              consumer ready; a pop happens only while valid_o=1
//          count_o            entries held, head included
//          data_o, valid_o    registered head byte and its valid flag
module gb_fetch_fifo
  import gb_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [7:0]             wdata_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [7:0]             data_o,
  output logic                   valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  opcode_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, count_after_pop;
  opcode_t         data_q, data_d;
  logic            valid_q;
  logic            pop;

  assign pop = valid_q && pop_i;

  // The head register always mirrors mem_q[rd_ptr_q]; when the FIFO is about
  // to be empty apart from an incoming byte, that byte bypasses into the head.
  always_comb begin
    rd_ptr_d        = rd_ptr_q + AW'(pop);
    count_after_pop = count_q - CW'(pop);
    count_d         = count_after_pop + CW'(push_i);
    data_d          = data_q;
    if (count_after_pop == '0) begin
      if (push_i) data_d = wdata_i;
    end else begin
      data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_i);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= (count_d != '0);
    end
  end

  assign count_o = count_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/gb_instr_fetch.sv
// rtl/gb_instr_fetch.sv - ROM-backed instruction fetch stage feeding gbprocessor
// Purpose: on start, reads length bytes from start_addr out of a one-cycle ROM,
//          buffers them and streams them out under a valid/ready handshake.
// Ports:   clock, reset (async, active-low)
//          start, start_addr, length   command, sampled only in IDLE
//          mem_rd, mem_addr, mem_rdata ROM port, data one cycle after mem_rd
//          instruction, valid, ready   opcode stream
//          busy, done                  status; done pulses after last transfer
module gb_instr_fetch
  import gb_fetch_pkg::*;
#(
  parameter int DEPTH  = FETCH_DEPTH_DEFAULT,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        instruction,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q, remaining_q;
  logic              inflight_q;
  logic              busy_q, done_q;
  logic [CW-1:0]     fifo_count;
  logic              issue, pop, drained;

  // Credit check: a read is issued only if the byte it returns is guaranteed
  // a free FIFO slot, counting the read already on its way back.
  assign issue = (state_q == FETCH) && (remaining_q != '0) &&
                 ((fifo_count + CW'(inflight_q)) < CW'(DEPTH));
  assign pop   = valid && ready;
  // FIFO will be empty after this edge and nothing is coming back from ROM.
  assign drained = !inflight_q && ((fifo_count - CW'(pop)) == '0);

  assign mem_rd   = issue;
  assign mem_addr = issue ? pc_q : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      inflight_q <= issue;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pc_q        <= start_addr;
            remaining_q <= length;
            busy_q      <= 1'b1;
            if (length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            pc_q        <= pc_q + ADDR_W'(1);
            remaining_q <= remaining_q - ADDR_W'(1);
            if (remaining_q == ADDR_W'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  gb_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (inflight_q),
    .wdata_i (mem_rdata),
    .pop_i   (ready),
    .count_o (fifo_count),
    .data_o  (instruction),
    .valid_o (valid)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_gb_instr_fetch.sv
// tb/tb_gb_instr_fetch.sv - directed self-checking bench for gb_instr_fetch
module tb_gb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] length;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  instruction;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        done;

  gb_instr_fetch dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .valid       (valid),
    .ready       (ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [7:0]  got[$];
  logic [15:0] addrs[$];
  int          n_done, stall_err, max_out, bad;
  logic        prev_stall;
  logic [7:0]  prev_instr;

  // ROM contents: low page holds its own address, other pages are scrambled
  function automatic logic [7:0] rom(input logic [15:0] a);
    return (a[15:8] == 8'h00) ? a[7:0] : (a[7:0] ^ 8'h5A);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Log the current cycle, advance one clock, then return the ROM data.
  task automatic step();
    logic        rd;
    logic [15:0] a;
    if (valid && ready) got.push_back(instruction);
    if (mem_rd) addrs.push_back(mem_addr);
    if (done) n_done++;
    if (prev_stall && (!valid || instruction !== prev_instr)) stall_err++;
    prev_stall = valid && !ready;
    prev_instr = instruction;
    if (addrs.size() - got.size() > max_out) max_out = addrs.size() - got.size();
    rd = mem_rd;
    a  = mem_addr;
    @(posedge clock);
    #1;
    mem_rdata = rd ? rom(a) : 8'hEE;
    cyc++;
  endtask

  // Issue start so that it is sampled at edge 0; returns in cycle 1.
  task automatic launch(input logic [15:0] addr, input logic [15:0] len);
    got.delete();
    addrs.delete();
    n_done = 0; stall_err = 0; max_out = 0; prev_stall = 1'b0;
    start = 1'b1; start_addr = addr; length = len;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  // mode 0: ready high; mode 1: ready pattern 1,0,0,1
  task automatic run(input int mode, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      step();
      k++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    ready = 1'b1;
    step();
    chk("done_pulse_fall", {31'd0, done}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    ready = 1'b1; mem_rdata = 8'h00;
    #1;
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    step(); step();
    chk("rst_instr", {24'd0, instruction}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    reset = 1'b1;
    step();

    // Basic: 256 bytes from 0x0000, ready held high
    launch(16'h0000, 16'd256);
    chk("lat_c1_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("lat_c1_addr", {16'd0, mem_addr}, 32'd0);
    chk("lat_c1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("lat_c2_valid", {31'd0, valid}, 32'd0);
    step();
    chk("lat_c3_valid", {31'd0, valid}, 32'd1);
    chk("lat_c3_instr", {24'd0, instruction}, 32'd0);
    run(0, 400);
    chk("basic_done_cycle", cyc - 1, 32'd259);
    chk("basic_count", got.size(), 32'd256);
    bad = 0;
    foreach (got[i]) if (got[i] !== 8'(i)) bad++;
    chk("basic_order", bad, 32'd0);
    chk("basic_reads", addrs.size(), 32'd256);
    chk("basic_done_pulses", n_done, 32'd1);

    // Back-pressure: 8 bytes from 0x0010, ready 1,0,0,1
    launch(16'h0010, 16'd8);
    run(1, 200);
    chk("bp_count", got.size(), 32'd8);
    bad = 0;
    foreach (got[i]) if (got[i] !== 8'(8'h10 + i)) bad++;
    chk("bp_order", bad, 32'd0);
    chk("bp_stall_hold", stall_err, 32'd0);
    chk("bp_outstanding", {31'd0, (max_out <= 5)}, 32'd1);
    chk("bp_reads", addrs.size(), 32'd8);

    // Address wrap: 0xFFFE, 4 bytes
    launch(16'hFFFE, 16'd4);
    run(0, 50);
    chk("wrap_reads", addrs.size(), 32'd4);
    if (addrs.size() == 4 && got.size() == 4) begin
      chk("wrap_a0", {16'd0, addrs[0]}, 32'hFFFE);
      chk("wrap_a1", {16'd0, addrs[1]}, 32'hFFFF);
      chk("wrap_a2", {16'd0, addrs[2]}, 32'h0000);
      chk("wrap_a3", {16'd0, addrs[3]}, 32'h0001);
      chk("wrap_d0", {24'd0, got[0]}, 32'hA4);
      chk("wrap_d1", {24'd0, got[1]}, 32'hA5);
      chk("wrap_d2", {24'd0, got[2]}, 32'h00);
      chk("wrap_d3", {24'd0, got[3]}, 32'h01);
    end else begin
      chk("wrap_bytes", got.size(), 32'd4);
    end

    // Zero length
    launch(16'h1234, 16'd0);
    chk("zero_c1_done", {31'd0, done}, 32'd1);
    chk("zero_c1_busy", {31'd0, busy}, 32'd1);
    chk("zero_c1_mem_rd", {31'd0, mem_rd}, 32'd0);
    step();
    chk("zero_c2_done", {31'd0, done}, 32'd0);
    chk("zero_c2_busy", {31'd0, busy}, 32'd0);
    chk("zero_reads", addrs.size(), 32'd0);

    // Start while busy is ignored
    launch(16'h0040, 16'd6);
    step(); step();
    start = 1'b1; start_addr = 16'h0080; length = 16'd3;
    step();
    start = 1'b0;
    run(0, 50);
    chk("busy_start_count", got.size(), 32'd6);
    bad = 0;
    foreach (got[i]) if (got[i] !== 8'(8'h40 + i)) bad++;
    chk("busy_start_order", bad, 32'd0);
    chk("busy_start_reads", addrs.size(), 32'd6);

    // Reset mid-stream with a read in flight
    launch(16'h0020, 16'd10);
    step(); step();
    chk("mid_valid_pre", {31'd0, valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("mid_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("mid_instr", {24'd0, instruction}, 32'd0);
    chk("mid_valid", {31'd0, valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    step();
    reset = 1'b1;
    step(); step();
    chk("post_rst_valid", {31'd0, valid}, 32'd0);
    launch(16'h0030, 16'd3);
    run(0, 50);
    chk("post_rst_count", got.size(), 32'd3);
    bad = 0;
    foreach (got[i]) if (got[i] !== 8'(8'h30 + i)) bad++;
    chk("post_rst_order", bad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gb_instr_fetch.md
# gb_instr_fetch

Instruction fetch stage directly upstream of `gbprocessor`. On a start command it reads a run of opcode bytes from a byte-wide synchronous program ROM, buffers them in a small prefetch FIFO, and presents them one per cycle on the `instruction`/`valid` pair that `gbprocessor` consumes. It replaces the bench-driven incrementing opcode stimulus with a memory-backed, back-pressure-aware instruction stream.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `ADDR_W`, 16: program address width.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first byte address; sampled with `start`.
- `length`  in  ADDR_W  number of bytes to deliver; sampled with `start`.
- `mem_rd`  out  1  ROM read strobe.
- `mem_addr`  out  ADDR_W  ROM read address, valid while `mem_rd`=1.
- `mem_rdata`  in  8  ROM data, valid exactly one cycle after `mem_rd`.
- `instruction`  out  8  opcode to `gbprocessor`.
- `valid`  out  1  `instruction` holds a delivered byte.
- `ready`  in  1  consumer accepts; tie high for `gbprocessor`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: `start`=1 latches `start_addr` into `pc` and `length` into `remaining`. Next state is FETCH, or DONE if `length`=0.
- FETCH: drive `mem_rd`=1 with `mem_addr`=`pc` whenever `fifo_count + inflight < DEPTH` and `remaining` ≠ 0.
  - Each issued read increments `pc`, wrapping modulo 2^ADDR_W so 0xFFFF→0x0000.
  - Each issued read decrements `remaining`.
  - `inflight` is 0 or 1; the returned `mem_rdata` is pushed into the FIFO on the cycle it arrives.
  - When `remaining` reaches 0, go to DRAIN.
- DRAIN: no reads. When FIFO is empty, `inflight`=0, and no transfer is pending, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Output handshake: a transfer occurs when `valid`&&`ready`. While `valid`=1 and `ready`=0, `instruction` is held stable. `valid` never drops without a transfer.
- Credit rule: the FIFO never overflows. Simultaneous push and pop on a full FIFO is legal and keeps `fifo_count` unchanged.
- `start` outside IDLE is ignored, with no effect on state or counters.
- Bytes are delivered in address order, exactly `length` bytes per command, with no duplicates.

## Timing
- Reset (`reset`=0, asynchronous) forces, regardless of state:
  - all outputs = 0 (`mem_rd`, `mem_addr`, `instruction`, `valid`, `busy`, `done`);
  - state = IDLE and FIFO empty;
  - `inflight` cleared, so a `mem_rdata` arriving after reset is discarded.
- Latency, with `start` sampled at edge 0:
  - `mem_rd`=1 in cycle 1;
  - data is pushed in cycle 2;
  - `valid`=1 in cycle 3.
- Throughput with `ready` held high: one byte per cycle after the first. DEPTH≥2 must sustain this with a one-cycle ROM.
- `done` is asserted the cycle after the final transfer. `busy` falls together with `done`'s falling edge, i.e. in the first IDLE cycle.
- `length`=0: `busy`=1 for one cycle (DONE), `done` pulses in the cycle after `start`, and there are no reads.

## Structure
- Package `gb_fetch_pkg`: `fetch_state_t` enum (IDLE, FETCH, DRAIN, DONE), `FETCH_DEPTH_DEFAULT`, and `opcode_t` (logic [7:0]), shared with `gbprocessor_iface`.
- Sub-module `gb_fetch_fifo`: parameterised synchronous FIFO (push, pop, count, registered head output driving `instruction`/`valid`).
- The top level holds the FSM, `pc`, `remaining`, `inflight`, and the credit check.

## Test plan
- Basic: ROM[n]=n, `start_addr`=0x0000, `length`=256, `ready`=1 → `valid` first at cycle 3; `instruction` = 0x00..0xFF on consecutive cycles; single `done`; exactly 256 `mem_rd`.
- Back-pressure: `length`=8, `ready` toggling 1,0,0,1 repeating → bytes unchanged while stalled; never more than 4 buffered plus 1 in flight; all 8 bytes delivered in order.
- Wrap: `start_addr`=0xFFFE, `length`=4 → `mem_addr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Zero length: `start` with `length`=0 → no `mem_rd`; `done` pulse at cycle 1; back in IDLE at cycle 2.
- Start while busy: second `start` during FETCH with a different address → ignored; the original stream completes unchanged.
- Reset mid-stream: `reset`=0 during FETCH while `inflight`=1 → all outputs are 0 immediately. A new `start` after release delivers only the new stream, with no stale byte.
